// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//  - md_op encodings (MD_MULT..MD_MSUB)
//  - FSM state encoding
//  - op classification helpers
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;
  localparam logic [2:0] MD_MADD  = 3'b110;
  localparam logic [2:0] MD_MSUB  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  // Ops that run the iterative datapath; MADD/MSUB only when accumulate is enabled.
  function automatic logic is_arith(input logic [2:0] op, input logic macc_en);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
      MD_MADD, MD_MSUB:                   return macc_en;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Ops whose operands are interpreted as two's complement.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
  endfunction

endpackage

// File: rtl/md_shift_core.sv
// Iterative magnitude datapath: radix-2 shift-add multiply or restoring divide,
// one bit per step.
//  clk, reset_n : clock, async active-low reset
//  div_i        : 1 = divide, 0 = multiply
//  load_i       : load operands, clear accumulator
//  step_i       : perform one iteration
//  x_i, y_i     : multiplicand/multiplier or dividend/divisor magnitudes
//  hi_o, lo_o   : product {hi,lo} or {remainder, quotient}
module md_shift_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             div_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] m_q, m_d;      // multiplicand or divisor
  logic [WIDTH-1:0] acc_q, acc_d;  // upper product or partial remainder
  logic [WIDTH-1:0] sh_q, sh_d;    // multiplier/lower product or dividend/quotient
  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   rem_try_c;
  logic [WIDTH-1:0] diff_c;

  // Next-state for one shift-add or shift-subtract iteration.
  always_comb begin
    sum_c     = {1'b0, acc_q} + (sh_q[0] ? {1'b0, m_q} : '0);
    rem_try_c = {acc_q, sh_q[WIDTH-1]};
    // Only taken when rem_try >= m, so the true difference fits WIDTH bits.
    diff_c    = rem_try_c[WIDTH-1:0] - m_q;
    m_d       = m_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    if (load_i) begin
      acc_d = '0;
      m_d   = div_i ? y_i : x_i;
      sh_d  = div_i ? x_i : y_i;
    end else if (step_i) begin
      if (div_i) begin
        if (rem_try_c >= {1'b0, m_q}) begin
          acc_d = diff_c;
          sh_d  = {sh_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_try_c[WIDTH-1:0];
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = sum_c[WIDTH:1];
        sh_d  = {sum_c[0], sh_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q   <= '0;
      acc_q <= '0;
      sh_q  <= '0;
    end else begin
      m_q   <= m_d;
      acc_q <= acc_d;
      sh_q  <= sh_d;
    end
  end

  assign hi_o = acc_q;
  assign lo_o = sh_q;

endmodule

// File: rtl/md_iter_unit.sv
// Iterative multiply/divide unit with HI/LO registers (EX stage).
//  clk, reset_n        : clock, async active-low reset
//  start, md_op        : issue request and operation code
//  data1, data2        : rs / rt operands
//  cancel              : abort in-flight op, suppress issue this cycle
//  hi, lo              : architectural HI/LO
//  busy                : op in flight or arithmetic op being issued (combinational)
//  done, div_by_zero   : commit pulse and its divide-by-zero flag
module md_iter_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter bit          ENABLE_MACC = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;      // result sign (product / quotient)
  logic             sgn1_q, sgn1_d;    // dividend sign, for remainder
  logic [WIDTH-1:0] d1_q, d1_d;        // raw dividend for divide-by-zero
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, dbz_q, dbz_d;

  logic             core_div_c, core_load_c, core_step_c, in_signed_c;
  logic [WIDTH-1:0] x_mag_c, y_mag_c, core_hi, core_lo, quot_c, rem_c;
  logic [W2-1:0]    prod_c, sprod_c;

  // Operand magnitudes; the core sees them only on load.
  always_comb begin
    in_signed_c = is_signed_op(md_op);
    x_mag_c     = (in_signed_c && data1[WIDTH-1]) ? (~data1 + WIDTH'(1)) : data1;
    y_mag_c     = (in_signed_c && data2[WIDTH-1]) ? (~data2 + WIDTH'(1)) : data2;
    core_div_c  = (state_q == ST_IDLE) ? is_div(md_op) : is_div(op_q);
  end

  md_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .div_i   (core_div_c),
    .load_i  (core_load_c),
    .step_i  (core_step_c),
    .x_i     (x_mag_c),
    .y_i     (y_mag_c),
    .hi_o    (core_hi),
    .lo_o    (core_lo)
  );

  // FSM next-state, sign correction and HI/LO commit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    neg_d       = neg_q;
    sgn1_d      = sgn1_q;
    d1_d        = d1_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    core_load_c = 1'b0;
    core_step_c = 1'b0;
    prod_c      = {core_hi, core_lo};
    sprod_c     = neg_q ? (~prod_c + W2'(1)) : prod_c;
    quot_c      = neg_q ? (~core_lo + WIDTH'(1)) : core_lo;
    rem_c       = sgn1_q ? (~core_hi + WIDTH'(1)) : core_hi;

    case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          if (is_arith(md_op, ENABLE_MACC)) begin
            op_d        = md_op;
            neg_d       = in_signed_c & (data1[WIDTH-1] ^ data2[WIDTH-1]);
            sgn1_d      = in_signed_c & data1[WIDTH-1];
            d1_d        = data1;
            dz_d        = (data2 == '0);
            ovf_d       = in_signed_c && (data1 == MIN_VAL) && (data2 == '1);
            cnt_d       = '0;
            core_load_c = 1'b1;
            state_d     = ST_CALC;
          end else if (md_op == MD_MTHI) begin
            hi_d = data1;
          end else if (md_op == MD_MTLO) begin
            lo_d = data1;
          end
        end
      end
      ST_CALC: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          core_step_c = 1'b1;
          cnt_d       = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          dbz_d  = 1'b0;
          case (op_q)
            MD_MULT, MD_MULTU: {hi_d, lo_d} = sprod_c;
            MD_MADD:           {hi_d, lo_d} = {hi_q, lo_q} + sprod_c;
            MD_MSUB:           {hi_d, lo_d} = {hi_q, lo_q} - sprod_c;
            MD_DIV, MD_DIVU: begin
              if (dz_q) begin
                lo_d  = '1;
                hi_d  = d1_q;
                dbz_d = 1'b1;
              end else if (ovf_q) begin
                lo_d = MIN_VAL;
                hi_d = '0;
              end else begin
                lo_d = quot_c;
                hi_d = rem_c;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MULT;
      neg_q   <= 1'b0;
      sgn1_q  <= 1'b0;
      d1_q    <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      sgn1_q  <= sgn1_d;
      d1_q    <= d1_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != ST_IDLE) | (start & is_arith(md_op, ENABLE_MACC));
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_md_iter_unit.sv
// Bench for md_iter_unit (WIDTH=32): transaction-level reference model checked
// every cycle, plus directed vectors with literal expectations.
module tb_md_iter_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         cancel = 1'b0;
  logic [2:0]   md_op = 3'b000;
  logic [W-1:0] data1 = '0;
  logic [W-1:0] data2 = '0;
  logic [W-1:0] hi, lo;
  logic         busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;
  int busy_cyc = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  md_iter_unit #(.WIDTH(W), .ENABLE_MACC(1'b1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .md_op       (md_op),
    .data1       (data1),
    .data2       (data2),
    .cancel      (cancel),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic arith(input logic [2:0] op);
    return (op != 3'b100) && (op != 3'b101);
  endfunction

  // Architectural result of one op, plain 64-bit arithmetic.
  function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] h, input logic [31:0] l,
                                 output logic [31:0] nh, output logic [31:0] nl, output logic dz);
    logic [63:0] p;
    logic [63:0] acc;
    longint sa, sb, q, r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = {h, l};
    nh  = h;
    nl  = l;
    dz  = 1'b0;
    case (op)
      3'd0: begin p = 64'(sa * sb); {nh, nl} = p; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; {nh, nl} = p; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          nh = a; nl = 32'hFFFF_FFFF; dz = 1'b1;
        end else if (op == 3'd2) begin
          q = sa / sb; r = sa % sb;
          nl = 32'(q); nh = 32'(r);
        end else begin
          nl = a / b; nh = a % b;
        end
      end
      3'd6: begin p = acc + 64'(sa * sb); {nh, nl} = p; end
      3'd7: begin p = acc - 64'(sa * sb); {nh, nl} = p; end
      default: ;
    endcase
  endfunction

  // Reference model: an op accepted in idle commits W+1 edges later.
  logic [31:0] m_hi, m_lo, p_a, p_b, c_hi, c_lo;
  logic [2:0]  p_op;
  logic        m_done, m_dz, c_dz;
  int          m_rem;

  always_comb ref_md(p_op, p_a, p_b, m_hi, m_lo, c_hi, c_lo, c_dz);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi <= '0; m_lo <= '0; m_rem <= 0; m_done <= 1'b0; m_dz <= 1'b0;
      p_op <= 3'd0; p_a <= '0; p_b <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_rem == 0) begin
        if (start && !cancel) begin
          if (arith(md_op)) begin
            m_rem <= W + 1; p_op <= md_op; p_a <= data1; p_b <= data2;
          end else if (md_op == 3'b100) m_hi <= data1;
          else m_lo <= data1;
        end
      end else if (cancel) begin
        m_rem <= 0;
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_hi <= c_hi; m_lo <= c_lo; m_dz <= c_dz; m_done <= 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("busy", 64'(busy), 64'((m_rem != 0) || (start && arith(md_op))));
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
      check("done", 64'(done), 64'(m_done));
      if (m_done) check("dbz", 64'(div_by_zero), 64'(m_dz));
      if (busy) busy_cyc++;
      if (done) done_cnt++;
    end
  end

  // Issue one arithmetic op, wait for done, check busy length and single pulse.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
    int  dc;
    bit  seen;
    @(posedge clk); #1;
    busy_cyc = 0;
    dc = done_cnt;
    start = 1'b1; md_op = op; data1 = a; data2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout got=no_done want=done", name);
    end
    check({name, "_hi"}, 64'(hi), 64'(exp_hi));
    check({name, "_lo"}, 64'(lo), 64'(exp_lo));
    check({name, "_busycyc"}, 64'(busy_cyc), 64'(W + 2));
    repeat (2) @(negedge clk);
    #1;
    check({name, "_donecnt"}, 64'(done_cnt - dc), 64'd1);
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    @(posedge clk); #1;
    start = 1'b1; md_op = op; data1 = a;
    @(negedge clk);
    check("mt_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dc;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk); #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    run_op(3'd3, 32'd7, 32'd2, 32'd1, 32'd3, "divu");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf");
    check("ovf_dbz", 64'(div_by_zero), 64'd0);
    run_op(3'd3, 32'h0000_000A, 32'd0, 32'h0000_000A, 32'hFFFF_FFFF, "divu_z");
    check("z_dbz", 64'(div_by_zero), 64'd1);
    run_op(3'd2, 32'd5, 32'd1, 32'd0, 32'd5, "div_51");
    check("51_dbz", 64'(div_by_zero), 64'd0);

    mt(3'b100, 32'd0);
    mt(3'b101, 32'd5);
    run_op(3'd6, 32'd3, 32'd4, 32'd0, 32'h0000_0011, "madd");
    run_op(3'd7, 32'd2, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "msub");

    // Cancel mid-multiply leaves HI/LO untouched.
    mt(3'b100, 32'hAA);
    mt(3'b101, 32'hAA);
    dc = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd0; data1 = 32'd6; data2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    check("cancel_hi", 64'(hi), 64'hAA);
    check("cancel_lo", 64'(lo), 64'hAA);
    check("cancel_nodone", 64'(done_cnt - dc), 64'd0);
    run_op(3'd0, 32'd6, 32'd7, 32'd0, 32'h2A, "mult_after");

    // Asynchronous reset in the middle of a divide.
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd2; data1 = 32'd100; data2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Random sweep; start is frequently asserted while busy.
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #1;
      start  = ($urandom % 3 == 0);
      md_op  = 3'($urandom % 8);
      data1  = pick();
      data2  = pick();
      cancel = ($urandom % 50 == 0);
    end
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
